// File: rtl/vector_sumsq32.sv
// vector_sumsq32: |X|^2 + |Y|^2 using one shared shift-add squarer on a REQ/BUSY/VALID handshake.
// Optional: define VECTOR_SUMSQ32_ZERO_SKIP_EN to skip the squaring phase of a zero component.
module vector_sumsq32 #(
   parameter int P_RADIX_BITS = 1
) (
   input  logic        iCLOCK,
   input  logic        inRESET,
   input  logic        iDATA_REQ,
   output logic        oDATA_BUSY,
   input  logic [15:0] iDATA_X,
   input  logic [15:0] iDATA_Y,
   output logic        oDATA_VALID,
   input  logic        iDATA_BUSY,
   output logic [31:0] oDATA
);
   localparam int N = 16 / P_RADIX_BITS;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SQX  = 2'd1,
      SQY  = 2'd2,
      OUT  = 2'd3
   } state_t;

   generate
      if (!(P_RADIX_BITS == 1 || P_RADIX_BITS == 2 || P_RADIX_BITS == 4)) begin : g_bad_radix
         $error("vector_sumsq32: P_RADIX_BITS must be 1, 2 or 4");
      end
   endgenerate

   // -32768 maps to 16'h8000, which still fits as an unsigned magnitude
   function automatic logic [15:0] abs16(input logic [15:0] v);
      abs16 = v[15] ? (16'd0 - v) : v;
   endfunction

   state_t      state_q, state_d;
   logic [15:0] mplier_q, mplier_d;
   logic [31:0] mcand_q, mcand_d;
   logic [15:0] ay_q, ay_d;
   logic [31:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] data_q, data_d;
   logic [15:0] abs_x_s, abs_y_s;
   logic [31:0] pp_s;
   logic        last_s;

   assign abs_x_s = abs16(iDATA_X);
   assign abs_y_s = abs16(iDATA_Y);
   assign last_s  = (cnt_q == 4'(N - 1));

   // Sum of the P_RADIX_BITS partial products retired this cycle
   always_comb begin
      pp_s = 32'd0;
      for (int i = 0; i < P_RADIX_BITS; i++) begin
         pp_s = pp_s + (mplier_q[i] ? (mcand_q << i) : 32'd0);
      end
   end

   // Next-state and datapath control
   always_comb begin
      state_d  = state_q;
      mplier_d = mplier_q;
      mcand_d  = mcand_q;
      ay_d     = ay_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      case (state_q)
         IDLE: begin
            if (iDATA_REQ) begin
               acc_d    = 32'd0;
               cnt_d    = 4'd0;
               ay_d     = abs_y_s;
               mplier_d = abs_x_s;
               mcand_d  = {16'd0, abs_x_s};
`ifdef VECTOR_SUMSQ32_ZERO_SKIP_EN
               if (abs_x_s == 16'd0 && abs_y_s == 16'd0) begin
                  data_d  = 32'd0;
                  state_d = OUT;
               end else if (abs_x_s == 16'd0) begin
                  mplier_d = abs_y_s;
                  mcand_d  = {16'd0, abs_y_s};
                  state_d  = SQY;
               end else begin
                  state_d = SQX;
               end
`else
               state_d = SQX;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         SQX: begin
            acc_d    = acc_q + pp_s;
            mplier_d = mplier_q >> P_RADIX_BITS;
            mcand_d  = mcand_q << P_RADIX_BITS;
            cnt_d    = cnt_q + 4'd1;
            if (last_s) begin
               // Reload the shared squarer with |Y| for the second phase
               cnt_d    = 4'd0;
               mplier_d = ay_q;
               mcand_d  = {16'd0, ay_q};
`ifdef VECTOR_SUMSQ32_ZERO_SKIP_EN
               if (ay_q == 16'd0) begin
                  data_d  = acc_q + pp_s;
                  state_d = OUT;
               end else begin
                  state_d = SQY;
               end
`else
               state_d = SQY;
`endif
            end else begin
               state_d = SQX;
            end
         end
         SQY: begin
            acc_d    = acc_q + pp_s;
            mplier_d = mplier_q >> P_RADIX_BITS;
            mcand_d  = mcand_q << P_RADIX_BITS;
            cnt_d    = cnt_q + 4'd1;
            if (last_s) begin
               cnt_d   = 4'd0;
               data_d  = acc_q + pp_s;
               state_d = OUT;
            end else begin
               state_d = SQY;
            end
         end
         OUT: begin
            if (!iDATA_BUSY) begin
               state_d = IDLE;
            end else begin
               state_d = OUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers, synchronous active-low reset
   always_ff @(posedge iCLOCK) begin
      if (!inRESET) begin
         state_q  <= IDLE;
         mplier_q <= 16'd0;
         mcand_q  <= 32'd0;
         ay_q     <= 16'd0;
         acc_q    <= 32'd0;
         cnt_q    <= 4'd0;
         data_q   <= 32'd0;
      end else begin
         state_q  <= state_d;
         mplier_q <= mplier_d;
         mcand_q  <= mcand_d;
         ay_q     <= ay_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         data_q   <= data_d;
      end
   end

   assign oDATA_BUSY  = (state_q != IDLE);
   assign oDATA_VALID = (state_q == OUT);
   assign oDATA       = data_q;

endmodule

// File: tb/tb_vector_sumsq32.sv
// Self-checking bench for vector_sumsq32: radix-1 and radix-4 instances against an arithmetic model.
module tb_vector_sumsq32;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req = 1'b0, dbusy = 1'b0, busy, valid;
   logic [15:0] xi = 16'd0, yi = 16'd0;
   logic [31:0] data;
   logic        req4 = 1'b0, dbusy4 = 1'b0, busy4, valid4;
   logic [15:0] x4 = 16'd0, y4 = 16'd0;
   logic [31:0] data4;
   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   vector_sumsq32 #(.P_RADIX_BITS(1)) dut (
      .iCLOCK(clk), .inRESET(rst_n), .iDATA_REQ(req), .oDATA_BUSY(busy),
      .iDATA_X(xi), .iDATA_Y(yi), .oDATA_VALID(valid), .iDATA_BUSY(dbusy), .oDATA(data));

   vector_sumsq32 #(.P_RADIX_BITS(4)) dut4 (
      .iCLOCK(clk), .inRESET(rst_n), .iDATA_REQ(req4), .oDATA_BUSY(busy4),
      .iDATA_X(x4), .iDATA_Y(y4), .oDATA_VALID(valid4), .iDATA_BUSY(dbusy4), .oDATA(data4));

   function automatic logic [31:0] model_sumsq(input logic [15:0] x, input logic [15:0] y);
      longint lx, ly;
      lx = longint'($signed(x));
      ly = longint'($signed(y));
      return 32'(lx * lx + ly * ly);
   endfunction

   function automatic int model_lat(input logic [15:0] x, input logic [15:0] y, input int n);
`ifdef VECTOR_SUMSQ32_ZERO_SKIP_EN
      return n * ((x != 16'd0 ? 1 : 0) + (y != 16'd0 ? 1 : 0));
`else
      return 2 * n;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drives one transaction on the radix-1 instance and reports what it observed
   task automatic do_txn(input logic [15:0] x, input logic [15:0] y, output int lat,
                         output logic [31:0] d, output int busy_cnt, output logic tmo);
      int guard;
      tmo = 1'b0;
      guard = 0;
      while (busy && guard < 200) begin tick(); guard++; end
      if (busy) tmo = 1'b1;
      req = 1'b1; xi = x; yi = y;
      tick();
      req = 1'b0;
      lat = 0; busy_cnt = 0;
      while (!valid && lat < 200) begin
         if (busy) busy_cnt++;
         tick();
         lat++;
      end
      if (!valid) tmo = 1'b1;
      d = data;
      guard = 0;
      while (busy && guard < 200) begin busy_cnt++; tick(); guard++; end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      tick(); tick();
      checks++; if (busy !== 1'b0 || valid !== 1'b0 || data !== 32'd0) begin
         failures++; $display("FAIL reset_r1 got busy=%b valid=%b data=%h exp 0/0/0", busy, valid, data); end
      checks++; if (busy4 !== 1'b0 || valid4 !== 1'b0 || data4 !== 32'd0) begin
         failures++; $display("FAIL reset_r4 got busy=%b valid=%b data=%h exp 0/0/0", busy4, valid4, data4); end
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int lat, bc; logic [31:0] d; logic tmo;
      do_txn(16'd3, 16'd4, lat, d, bc, tmo);
      checks++; if (tmo !== 1'b0) begin failures++; $display("FAIL basic_timeout got=%b exp=0", tmo); end
      checks++; if (d !== 32'h19) begin failures++; $display("FAIL basic_data got=%h exp=%h", d, 32'h19); end
      checks++; if (lat != 32) begin failures++; $display("FAIL basic_latency got=%0d exp=32", lat); end
      checks++; if (bc != 33) begin failures++; $display("FAIL basic_busy_cycles got=%0d exp=33", bc); end
      checks++; if (valid !== 1'b0) begin failures++; $display("FAIL basic_valid_one_cycle got=%b exp=0", valid); end
   endtask

   task automatic test_extremes();
      logic [15:0] xs [5] = '{16'h8000, 16'h7FFF, 16'h0000, 16'h0000, 16'h0007};
      logic [15:0] ys [5] = '{16'h8000, 16'hFFFF, 16'h0000, 16'h0005, 16'h0000};
      logic [31:0] ex [5] = '{32'h80000000, 32'h3FFF0002, 32'h0, 32'd25, 32'd49};
      int lat, bc; logic [31:0] d; logic tmo;
      for (int i = 0; i < 5; i++) begin
         do_txn(xs[i], ys[i], lat, d, bc, tmo);
         checks++; if (tmo !== 1'b0 || d !== ex[i]) begin
            failures++; $display("FAIL extreme_data[%0d] got=%h tmo=%b exp=%h", i, d, tmo, ex[i]); end
         checks++; if (lat != model_lat(xs[i], ys[i], 16)) begin
            failures++; $display("FAIL extreme_latency[%0d] got=%0d exp=%0d", i, lat, model_lat(xs[i], ys[i], 16)); end
         checks++; if (bc != lat + 1) begin
            failures++; $display("FAIL extreme_busy[%0d] got=%0d exp=%0d", i, bc, lat + 1); end
      end
   endtask

   task automatic test_random();
      int lat, bc; logic [31:0] d; logic tmo; logic [15:0] x, y;
      for (int i = 0; i < 12; i++) begin
         x = 16'($urandom);
         y = 16'($urandom);
         if (i % 5 == 3) x = 16'd0;
         if (i % 7 == 4) y = 16'd0;
         do_txn(x, y, lat, d, bc, tmo);
         checks++; if (tmo !== 1'b0 || d !== model_sumsq(x, y) || lat != model_lat(x, y, 16)) begin
            failures++;
            $display("FAIL random[%0d] x=%h y=%h got=%h lat=%0d exp=%h lat=%0d", i, x, y, d, lat,
                     model_sumsq(x, y), model_lat(x, y, 16));
         end
      end
   endtask

   task automatic test_backpressure();
      int guard, lat, stable_bad;
      logic [31:0] exp1, exp2;
      exp1 = model_sumsq(16'd100, 16'hFF38);
      exp2 = model_sumsq(16'd5, 16'd6);
      dbusy = 1'b1;
      req = 1'b1; xi = 16'd100; yi = 16'hFF38;
      tick();
      req = 1'b0;
      guard = 0;
      while (!valid && guard < 200) begin tick(); guard++; end
      checks++; if (valid !== 1'b1) begin failures++; $display("FAIL bp_valid_seen got=%b exp=1", valid); end
      // A new request held through the back-pressure window must not be taken
      req = 1'b1; xi = 16'd5; yi = 16'd6;
      stable_bad = 0;
      for (int i = 0; i < 10; i++) begin
         if (valid !== 1'b1 || data !== exp1 || busy !== 1'b1) stable_bad++;
         if (i == 9) dbusy = 1'b0;
         tick();
      end
      checks++; if (stable_bad != 0) begin failures++; $display("FAIL bp_stable got=%0d bad cycles exp=0", stable_bad); end
      checks++; if (valid !== 1'b0 || busy !== 1'b0 || data !== exp1) begin
         failures++; $display("FAIL bp_transfer got valid=%b busy=%b data=%h exp 0/0/%h", valid, busy, data, exp1); end
      tick();
      req = 1'b0;
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL bp_held_accept got=%b exp=1", busy); end
      lat = 0;
      while (!valid && lat < 200) begin tick(); lat++; end
      checks++; if (data !== exp2 || lat != model_lat(16'd5, 16'd6, 16)) begin
         failures++; $display("FAIL bp_second got=%h lat=%0d exp=%h lat=%0d", data, lat, exp2, model_lat(16'd5, 16'd6, 16)); end
      tick();
   endtask

   task automatic test_reset_midop();
      int lat, bc, seen; logic [31:0] d; logic tmo;
      req = 1'b1; xi = 16'd300; yi = 16'd400;
      tick();
      req = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      rst_n = 1'b0;
      tick();
      checks++; if (busy !== 1'b0 || valid !== 1'b0 || data !== 32'd0) begin
         failures++; $display("FAIL midop_reset got busy=%b valid=%b data=%h exp 0/0/0", busy, valid, data); end
      rst_n = 1'b1;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         if (valid || busy) seen++;
         tick();
      end
      checks++; if (seen != 0) begin failures++; $display("FAIL midop_no_valid got=%0d active cycles exp=0", seen); end
      do_txn(16'd1, 16'd1, lat, d, bc, tmo);
      checks++; if (tmo !== 1'b0 || d !== 32'd2) begin
         failures++; $display("FAIL midop_after got=%h tmo=%b exp=%h", d, tmo, 32'd2); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] qx [4], qy [4];
      int acc_cyc [4], val_cyc [4];
      logic [31:0] got [4];
      int n_acc, n_val;
      logic pre_busy;
      for (int i = 0; i < 4; i++) begin
         qx[i] = 16'($urandom_range(1, 32767));
         qy[i] = 16'($urandom_range(1, 32767));
         if ($urandom_range(0, 1) == 1) qx[i] = 16'd0 - qx[i];
         if ($urandom_range(0, 1) == 1) qy[i] = 16'd0 - qy[i];
      end
      n_acc = 0; n_val = 0;
      req4 = 1'b1; x4 = qx[0]; y4 = qy[0];
      for (int cyc = 1; cyc <= 200 && n_val < 4; cyc++) begin
         pre_busy = busy4;
         tick();
         if (!pre_busy && req4) begin
            acc_cyc[n_acc] = cyc;
            n_acc++;
            if (n_acc < 4) begin x4 = qx[n_acc]; y4 = qy[n_acc]; end
            else req4 = 1'b0;
         end
         if (valid4 && n_val < 4) begin
            val_cyc[n_val] = cyc;
            got[n_val] = data4;
            n_val++;
         end
      end
      req4 = 1'b0;
      checks++; if (n_acc != 4 || n_val != 4) begin
         failures++; $display("FAIL b2b_counts got acc=%0d val=%0d exp 4/4", n_acc, n_val); end
      for (int i = 0; i < n_val && i < n_acc; i++) begin
         checks++; if (got[i] !== model_sumsq(qx[i], qy[i])) begin
            failures++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, got[i], model_sumsq(qx[i], qy[i])); end
         checks++; if (val_cyc[i] - acc_cyc[i] != 8) begin
            failures++; $display("FAIL b2b_latency[%0d] got=%0d exp=8", i, val_cyc[i] - acc_cyc[i]); end
         if (i > 0) begin
            checks++; if (acc_cyc[i] - acc_cyc[i-1] != 10) begin
               failures++; $display("FAIL b2b_spacing[%0d] got=%0d exp=10", i, acc_cyc[i] - acc_cyc[i-1]); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_extremes();
      test_random();
      test_backpressure();
      test_reset_midop();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
